// File: rtl/msrv_32_addr_gen_unit.sv
// Two-stage elastic address generator: base + imm, JALR clear, tag sideband.
// Define MSRV_32_AGU_MISALIGN_CHECK_EN to enable the misalignment flag.
module msrv_32_addr_gen_unit #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   input  logic             flush_in,
   input  logic             valid_in,
   output logic             ready_out,
   input  logic [XLEN-1:0]  rs_1_in,
   input  logic [XLEN-1:0]  pc_in,
   input  logic [XLEN-1:0]  imm_in,
   input  logic             iadder_src_in,
   input  logic             jalr_in,
   input  logic [1:0]       size_in,
   input  logic [TAG_W-1:0] tag_in,
   output logic             valid_out,
   input  logic             ready_in,
   output logic [XLEN-1:0]  iadder_out,
   output logic [TAG_W-1:0] tag_out,
   output logic             misaligned_out
);

   logic             s1_valid_q;
   logic             s2_valid_q;
   logic [XLEN-1:0]  base_q;
   logic [XLEN-1:0]  imm_q;
   logic             jalr_q;
   logic [TAG_W-1:0] tag1_q;
   logic [XLEN-1:0]  sum_d;
   logic [XLEN-1:0]  sum_q;
   logic [TAG_W-1:0] tag2_q;
   logic             s2_free;
   logic             s1_load;
   logic             s2_load;

   assign s2_free   = !s2_valid_q || ready_in;
   assign ready_out = !s1_valid_q || s2_free;
   assign s1_load   = valid_in && ready_out;
   assign s2_load   = s1_valid_q && s2_free;

   assign valid_out  = s2_valid_q;
   assign iadder_out = sum_q;
   assign tag_out    = tag2_q;

   // Stage valid bits; flush wins over any incoming transfer
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
      end else if (flush_in) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
      end else begin
         if (ready_out) s1_valid_q <= valid_in;
         if (s2_free)   s2_valid_q <= s1_valid_q;
      end
   end

   // Sum with carry dropped; JALR clears bit 0 before any alignment check
   always_comb begin
      sum_d = base_q + imm_q;
      if (jalr_q) sum_d[0] = 1'b0;
   end

   // S1 data capture: selected base operand plus sideband
   always_ff @(posedge clk_in) begin
      if (s1_load) begin
         base_q <= iadder_src_in ? rs_1_in : pc_in;
         imm_q  <= imm_in;
         jalr_q <= jalr_in;
         tag1_q <= tag_in;
      end
   end

   // S2 data capture: final address and tag
   always_ff @(posedge clk_in) begin
      if (s2_load) begin
         sum_q  <= sum_d;
         tag2_q <= tag1_q;
      end
   end

`ifdef MSRV_32_AGU_MISALIGN_CHECK_EN
   logic [1:0] size_q;
   logic [1:0] eff_size;
   logic       mis_d;
   logic       mis_q;

   // RV32 has no dword access, so size 11 falls back to word
   assign eff_size = (XLEN == 32 && size_q == 2'b11) ? 2'b10 : size_q;

   // Alignment test on the post-JALR address
   always_comb begin
      mis_d = 1'b0;
      case (eff_size)
         2'b01:   mis_d = sum_d[0];
         2'b10:   mis_d = |sum_d[1:0];
         2'b11:   mis_d = |sum_d[2:0];
         default: mis_d = 1'b0;
      endcase
   end

   // Access size rides in S1 alongside the operands
   always_ff @(posedge clk_in) begin
      if (s1_load) size_q <= size_in;
   end

   // Misalignment flag rides in S2 alongside the sum
   always_ff @(posedge clk_in) begin
      if (s2_load) mis_q <= mis_d;
   end

   assign misaligned_out = s2_valid_q && mis_q;
`else
   logic size_unused;

   assign size_unused    = ^size_in;
   assign misaligned_out = 1'b0;
`endif

endmodule

// File: tb/tb_msrv_32_addr_gen_unit.sv
// Self-checking bench for msrv_32_addr_gen_unit (XLEN=32, TAG_W=5).
// Honours MSRV_32_AGU_MISALIGN_CHECK_EN when choosing expected flags.
module tb_msrv_32_addr_gen_unit;

`ifdef MSRV_32_AGU_MISALIGN_CHECK_EN
   localparam bit MIS_EN = 1'b1;
`else
   localparam bit MIS_EN = 1'b0;
`endif

   typedef struct {
      logic [31:0] rs1;
      logic [31:0] pc;
      logic [31:0] imm;
      logic        src;
      logic        jalr;
      logic [1:0]  size;
      logic [4:0]  tag;
      logic [31:0] addr;
      logic        mis;
   } vec_t;

   typedef struct {
      logic [31:0] addr;
      logic [4:0]  tag;
      logic        mis;
   } exp_t;

   logic        clk_in = 1'b0;
   logic        rst_n_in;
   logic        flush_in;
   logic        valid_in;
   logic        ready_out;
   logic [31:0] rs_1_in;
   logic [31:0] pc_in;
   logic [31:0] imm_in;
   logic        iadder_src_in;
   logic        jalr_in;
   logic [1:0]  size_in;
   logic [4:0]  tag_in;
   logic        valid_out;
   logic        ready_in;
   logic [31:0] iadder_out;
   logic [4:0]  tag_out;
   logic        misaligned_out;

   int   nchk = 0;
   int   nerr = 0;
   exp_t sb[$];
   exp_t cur;
   vec_t vt[11];

   msrv_32_addr_gen_unit #(.XLEN(32), .TAG_W(5)) dut (
      .clk_in         (clk_in),
      .rst_n_in       (rst_n_in),
      .flush_in       (flush_in),
      .valid_in       (valid_in),
      .ready_out      (ready_out),
      .rs_1_in        (rs_1_in),
      .pc_in          (pc_in),
      .imm_in         (imm_in),
      .iadder_src_in  (iadder_src_in),
      .jalr_in        (jalr_in),
      .size_in        (size_in),
      .tag_in         (tag_in),
      .valid_out      (valid_out),
      .ready_in       (ready_in),
      .iadder_out     (iadder_out),
      .tag_out        (tag_out),
      .misaligned_out (misaligned_out)
   );

   always #5 clk_in = ~clk_in;

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] rs1, pc, imm,
                               input logic src, jalr,
                               input logic [1:0] size,
                               input logic [4:0] tag);
      vec_t       v;
      logic [31:0] a;
      logic [1:0]  s;
      a = (src ? rs1 : pc) + imm;
      if (jalr) a[0] = 1'b0;
      s = (size == 2'b11) ? 2'b10 : size;
      v.rs1  = rs1;
      v.pc   = pc;
      v.imm  = imm;
      v.src  = src;
      v.jalr = jalr;
      v.size = size;
      v.tag  = tag;
      v.addr = a;
      v.mis  = (s == 2'b01 && a[0]) || (s == 2'b10 && a[1:0] != 2'b00);
      return v;
   endfunction

   task automatic drive(input vec_t v);
      rs_1_in       = v.rs1;
      pc_in         = v.pc;
      imm_in        = v.imm;
      iadder_src_in = v.src;
      jalr_in       = v.jalr;
      size_in       = v.size;
      tag_in        = v.tag;
      valid_in      = 1'b1;
      cur.addr      = v.addr;
      cur.tag       = v.tag;
      cur.mis       = v.mis & MIS_EN;
   endtask

   // Sample mid-cycle, score the output handshake, log the input one, advance
   task automatic tick(output bit acc);
      exp_t e;
      #1;
      acc = rst_n_in && valid_in && ready_out && !flush_in;
      if (valid_out && ready_in) begin
         if (sb.size() == 0) begin
            chk("unexpected_out", {59'd0, tag_out}, 64'hFFFF);
         end else begin
            e = sb.pop_front();
            chk("addr", iadder_out, e.addr);
            chk("tag", tag_out, e.tag);
            chk("mis", misaligned_out, e.mis);
         end
      end
      if (flush_in) sb.delete();
      if (acc) sb.push_back(cur);
      @(posedge clk_in);
      @(negedge clk_in);
   endtask

   task automatic drain();
      bit a;
      int n = 0;
      valid_in = 1'b0;
      while ((sb.size() != 0 || valid_out) && n < 20) begin
         tick(a);
         n++;
      end
      chk("drain", sb.size(), 0);
   endtask

   initial begin
      bit   a;
      int   n;
      vec_t v1, v2, v3;

      vt[0]  = '{32'hAABBCCDD, 32'h0, 32'h12345678, 1'b1, 1'b0, 2'b00,
                 5'd1, 32'hBCF02355, 1'b0};
      vt[1]  = '{32'h0, 32'h00010000, 32'h87654321, 1'b0, 1'b0, 2'b00,
                 5'd2, 32'h87664321, 1'b0};
      vt[2]  = '{32'hFFFFFFFF, 32'h0, 32'h00000001, 1'b1, 1'b0, 2'b11,
                 5'd3, 32'h00000000, 1'b0};
      vt[3]  = '{32'h00001003, 32'h0, 32'h0, 1'b1, 1'b1, 2'b10,
                 5'd4, 32'h00001002, 1'b1};
      vt[4]  = '{32'h00001003, 32'h0, 32'h0, 1'b1, 1'b1, 2'b01,
                 5'd5, 32'h00001002, 1'b0};
      vt[5]  = '{32'h0, 32'h0, 32'h00000002, 1'b1, 1'b0, 2'b10,
                 5'd6, 32'h00000002, 1'b1};
      vt[6]  = '{32'h0, 32'h0, 32'h00000004, 1'b1, 1'b0, 2'b01,
                 5'd7, 32'h00000004, 1'b0};
      vt[7]  = '{32'h0, 32'h0, 32'h00000004, 1'b1, 1'b0, 2'b11,
                 5'd8, 32'h00000004, 1'b0};
      vt[8]  = '{32'h0, 32'h0, 32'h00000001, 1'b1, 1'b0, 2'b00,
                 5'd9, 32'h00000001, 1'b0};
      vt[9]  = '{32'h0, 32'h0, 32'h00000003, 1'b1, 1'b0, 2'b01,
                 5'd10, 32'h00000003, 1'b1};
      vt[10] = '{32'h0, 32'h0, 32'h00000006, 1'b1, 1'b0, 2'b11,
                 5'd11, 32'h00000006, 1'b1};

      rst_n_in = 1'b0;
      flush_in = 1'b0;
      valid_in = 1'b0;
      ready_in = 1'b1;
      rs_1_in = '0;
      pc_in = '0;
      imm_in = '0;
      iadder_src_in = 1'b0;
      jalr_in = 1'b0;
      size_in = '0;
      tag_in = '0;

      #3;
      chk("rst_valid_out", valid_out, 0);
      chk("rst_ready_out", ready_out, 1);
      chk("rst_mis", misaligned_out, 0);
      @(negedge clk_in);
      rst_n_in = 1'b1;

      // latency: one op in isolation
      drive(vt[0]);
      tick(a);
      chk("lat_acc", a, 1);
      valid_in = 1'b0;
      #1 chk("lat_1edge", valid_out, 0);
      tick(a);
      #1 chk("lat_2edge", valid_out, 1);
      drain();

      // table stream, back to back
      for (int i = 0; i < 11; i++) begin
         drive(vt[i]);
         tick(a);
         chk("stream_acc", a, 1);
      end
      drain();

      // backpressure with tags 1,2,3
      ready_in = 1'b0;
      v1 = mk(32'h100, 32'h0, 32'h4, 1'b1, 1'b0, 2'b10, 5'd1);
      v2 = mk(32'h200, 32'h0, 32'h5, 1'b1, 1'b0, 2'b01, 5'd2);
      v3 = mk(32'h0, 32'h300, 32'h7, 1'b0, 1'b1, 2'b10, 5'd3);
      drive(v1);
      tick(a);
      chk("bp_acc1", a, 1);
      drive(v2);
      tick(a);
      chk("bp_acc2", a, 1);
      drive(v3);
      for (int k = 0; k < 2; k++) begin
         #1;
         chk("bp_ready_out", ready_out, 0);
         chk("bp_valid_out", valid_out, 1);
         chk("bp_hold_tag", tag_out, 1);
         chk("bp_hold_addr", iadder_out, v1.addr);
         tick(a);
         chk("bp_stall", a, 0);
      end
      ready_in = 1'b1;
      n = 0;
      a = 1'b0;
      while (!a && n < 10) begin
         tick(a);
         n++;
      end
      chk("bp_acc3", a, 1);
      drain();

      // flush with two ops in flight plus a simultaneous input
      drive(mk(32'h10, 32'h0, 32'h10, 1'b1, 1'b0, 2'b10, 5'd12));
      tick(a);
      drive(mk(32'h20, 32'h0, 32'h10, 1'b1, 1'b0, 2'b10, 5'd13));
      tick(a);
      ready_in = 1'b0;
      flush_in = 1'b1;
      drive(mk(32'h30, 32'h0, 32'h10, 1'b1, 1'b0, 2'b10, 5'd14));
      tick(a);
      flush_in = 1'b0;
      valid_in = 1'b0;
      ready_in = 1'b1;
      #1;
      chk("flush_valid_out", valid_out, 0);
      chk("flush_ready_out", ready_out, 1);
      repeat (3) tick(a);
      chk("flush_dropped", valid_out, 0);
      drive(mk(32'h40, 32'h0, 32'h1, 1'b1, 1'b0, 2'b01, 5'd15));
      tick(a);
      chk("flush_resume_acc", a, 1);
      drain();

      // reset pulse mid-stream
      drive(mk(32'h50, 32'h0, 32'h2, 1'b1, 1'b0, 2'b10, 5'd16));
      tick(a);
      drive(mk(32'h60, 32'h0, 32'h3, 1'b1, 1'b0, 2'b00, 5'd17));
      tick(a);
      rst_n_in = 1'b0;
      valid_in = 1'b0;
      #1;
      chk("mrst_valid_out", valid_out, 0);
      chk("mrst_ready_out", ready_out, 1);
      chk("mrst_mis", misaligned_out, 0);
      sb.delete();
      tick(a);
      rst_n_in = 1'b1;
      drive(mk(32'h70, 32'h0, 32'h1, 1'b1, 1'b1, 2'b01, 5'd18));
      tick(a);
      chk("mrst_resume_acc", a, 1);
      drain();

      chk("sb_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
